// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the 16-bit pattern generator/checker pair
// Contents: LFSR width, tap positions, default seed, checker state encoding,
//           next-state function lfsr_next_f (next = {x[14:0], x15^x12^x5^x0}).
package lfsr_pkg;
    localparam int LFSR_W = 16;
    localparam int TAP_A = 15;
    localparam int TAP_B = 12;
    localparam int TAP_C = 5;
    localparam int TAP_D = 0;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;
    function automatic logic [LFSR_W-1:0] lfsr_next_f(input logic [LFSR_W-1:0] x);
        return {x[LFSR_W-2:0], x[TAP_A] ^ x[TAP_B] ^ x[TAP_C] ^ x[TAP_D]};
    endfunction
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational one-step advance of the 16-bit pattern LFSR
// Ports: x_i (current word), x_o (next word in the sequence)
module lfsr_step
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] x_i,
    output logic [LFSR_W-1:0] x_o
);
    assign x_o = lfsr_next_f(x_i);
endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising checker for the 16-bit LFSR pattern stream
// Ports: clk, resetn (sync, active-low), in_valid/in_data (received words),
//        clear_cnt (clears err_count and signature), locked, err_pulse,
//        err_count (saturating), signature (MISR, only with LFSR_CHK_SIGNATURE_EN,
//        otherwise tied to zero).
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 8,
    parameter int LOSS_COUNT = 4,
    parameter int ERR_W      = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [LFSR_W-1:0] in_data,
    input  logic              clear_cnt,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [LFSR_W-1:0] signature
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int NW = $clog2(LOSS_COUNT + 1);

    state_t            state_q;
    logic [LFSR_W-1:0] pred_q, step_in, pred_d;
    logic              pred_vld_q, err_pulse_q, hit;
    logic [MW-1:0]     match_q;
    logic [NW-1:0]     miss_q;
    logic [ERR_W-1:0]  err_count_q;

    assign hit = pred_vld_q && in_data == pred_q;
    // SEARCH reloads from the received word on any miss; LOCKED flywheels on the predictor
    assign step_in = (state_q == ST_SEARCH && !hit) ? in_data : pred_q;

    lfsr_step u_pred_step (.x_i(step_in), .x_o(pred_d));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_SEARCH;
            pred_q      <= '0;
            pred_vld_q  <= 1'b0;
            match_q     <= '0;
            miss_q      <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (in_valid) begin
                pred_q <= pred_d;
                if (state_q == ST_SEARCH) begin
                    // all-zero is the LFSR lock-up value and never seeds the predictor
                    if (in_data == '0) begin
                        pred_vld_q <= 1'b0;
                        match_q    <= '0;
                    end else if (!hit) begin
                        pred_vld_q <= 1'b1;
                        match_q    <= '0;
                    end else if (match_q == MW'(LOCK_COUNT - 1)) begin
                        state_q <= ST_LOCKED;
                        match_q <= '0;
                    end else begin
                        match_q <= match_q + 1'b1;
                    end
                end else if (hit) begin
                    miss_q <= '0;
                end else begin
                    err_pulse_q <= 1'b1;
                    err_count_q <= (&err_count_q) ? err_count_q : err_count_q + 1'b1;
                    if (miss_q == NW'(LOSS_COUNT - 1)) begin
                        state_q    <= ST_SEARCH;
                        pred_vld_q <= 1'b0;
                        miss_q     <= '0;
                    end else begin
                        miss_q <= miss_q + 1'b1;
                    end
                end
            end
            if (clear_cnt) err_count_q <= '0;
        end
    end

    assign locked    = state_q == ST_LOCKED;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

`ifdef LFSR_CHK_SIGNATURE_EN
    logic [LFSR_W-1:0] sig_q, sig_d;

    lfsr_step u_sig_step (.x_i(sig_q), .x_o(sig_d));

    always_ff @(posedge clk) begin
        if (!resetn || clear_cnt) sig_q <= '0;
        else if (in_valid) sig_q <= sig_d ^ in_data;
    end

    assign signature = sig_q;
`else
    assign signature = '0;
`endif
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed self-checking bench for lfsr_checker (err_count narrowed to 4 bits)
module tb_lfsr_checker;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        clear_cnt = 1'b0;
    logic        locked, err_pulse;
    logic [3:0]  err_count;
    logic [15:0] signature;
    logic [15:0] g, sig_m;
    int          errors = 0;
    int          checks = 0;

    lfsr_checker #(.LOCK_COUNT(8), .LOSS_COUNT(4), .ERR_W(4)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .clear_cnt(clear_cnt), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .signature(signature)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] nx(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[12] ^ x[5] ^ x[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic c);
        in_valid = v; in_data = d; clear_cnt = c;
`ifdef LFSR_CHK_SIGNATURE_EN
        if (c) sig_m = '0;
        else if (v) sig_m = nx(sig_m) ^ d;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0; clear_cnt = 1'b0;
    endtask

    task automatic good();
        step(1'b1, g, 1'b0);
        g = nx(g);
    endtask

    task automatic bad(input logic [15:0] m);
        step(1'b1, g ^ m, 1'b0);
        g = nx(g);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk); #1;
        sig_m = '0;
        resetn = 1'b1;
    endtask

    initial begin
        sig_m = '0;
        g = 16'hACE1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_pulse", err_pulse, 0);
        chk("rst_count", err_count, 0);
        chk("rst_sig", signature, 0);
        resetn = 1'b1;
        // 1: clean stream from the seed locks on the 9th word
        chk("seed_next", nx(g), 16'h59C3);
        for (int i = 0; i < 8; i++) good();
        chk("t1_not_yet", locked, 0);
        good();
        chk("t1_locked", locked, 1);
        chk("t1_count", err_count, 0);
        chk("t1_pulse", err_pulse, 0);
        // 2: single corrupted word
        bad(16'h0001);
        chk("t2_pulse", err_pulse, 1);
        chk("t2_count", err_count, 1);
        chk("t2_locked", locked, 1);
        good();
        chk("t2_pulse_clr", err_pulse, 0);
        chk("t2_count_hold", err_count, 1);
        // 3: four consecutive corrupted words lose lock, then relock
        step(1'b0, 16'h0000, 1'b1);
        chk("t3_clear", err_count, 0);
        for (int i = 0; i < 3; i++) bad(16'h0100);
        chk("t3_still_locked", locked, 1);
        chk("t3_count3", err_count, 3);
        bad(16'h0100);
        chk("t3_lost", locked, 0);
        chk("t3_count4", err_count, 4);
        chk("t3_pulse", err_pulse, 1);
        for (int i = 0; i < 8; i++) good();
        chk("t3_search", locked, 0);
        chk("t3_no_search_err", err_count, 4);
        good();
        chk("t3_relock", locked, 1);
        // 6b: reset while locked
        bad(16'h0001);
        chk("t6_count_pre", err_count, 5);
        do_reset();
        chk("t6_rst_locked", locked, 0);
        chk("t6_rst_count", err_count, 0);
        chk("t6_rst_pulse", err_pulse, 0);
        // 4: 1-of-3 valid duty during sync
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'h1234, 1'b0);
            step(1'b0, 16'h5678, 1'b0);
            good();
        end
        chk("t4_not_yet", locked, 0);
        step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'hFFFF, 1'b0);
        good();
        chk("t4_locked", locked, 1);
        step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'hBEEF, 1'b0);
        chk("t4_idle_locked", locked, 1);
        chk("t4_idle_count", err_count, 0);
        bad(16'h8000);
        chk("t4_pulse", err_pulse, 1);
        step(1'b0, 16'h0000, 1'b0);
        chk("t4_idle_pulse", err_pulse, 0);
        chk("t4_idle_hold", err_count, 1);
        good();
        chk("t4_match_after_gap", err_pulse, 0);
        // 5: saturation and clear-vs-error priority
        step(1'b0, 16'h0000, 1'b1);
        chk("t5_clear", err_count, 0);
        for (int i = 0; i < 15; i++) begin
            bad(16'h0001);
            good();
        end
        chk("t5_full", err_count, 4'hF);
        chk("t5_locked", locked, 1);
        bad(16'h0001);
        chk("t5_sat", err_count, 4'hF);
        chk("t5_sat_pulse", err_pulse, 1);
        good();
        step(1'b1, g ^ 16'h0001, 1'b1);
        g = nx(g);
        chk("t5_clear_wins", err_count, 0);
        chk("t5_clear_pulse", err_pulse, 1);
        chk("t5_clear_locked", locked, 1);
        chk("t5_sig", signature, sig_m);
        // 6a: zero word breaks sync, all-zero stream never locks
        do_reset();
        g = 16'hACE1;
        for (int i = 0; i < 5; i++) good();
        step(1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 8; i++) good();
        chk("t6_zero_resync", locked, 0);
        good();
        chk("t6_relock", locked, 1);
        chk("t6_sig", signature, sig_m);
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 16'h0000, 1'b0);
        chk("t6_zero_locked", locked, 0);
        chk("t6_zero_count", err_count, 0);
        chk("t6_zero_pulse", err_pulse, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
